// File: rtl/cfg_regfile_ctrl.sv
// cfg_regfile_ctrl: shadow/active configuration register file with run
// sequencer (IDLE -> LAUNCH -> RUN -> DONE), addressed readback, optional
// run timeout, sticky error flags and a wrapping completed-run counter.
module cfg_regfile_ctrl #(
  parameter int CFG_W   = 16,
  parameter int N_REGS  = 4,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [CFG_W-1:0]         i_cfg,
  input  logic [ADDR_W-1:0]        i_cfg_addr,
  input  logic                     i_cfg_wr_en,
  input  logic                     i_cfg_rd_en,
  input  logic                     i_cfg_rd_active,
  output logic [CFG_W-1:0]         o_cfg_rd_data,
  output logic                     o_cfg_rd_valid,
  input  logic                     i_start,
  input  logic                     i_core_done,
  input  logic                     i_err_clr,
  output logic [N_REGS*CFG_W-1:0]  o_cfg_active,
  output logic                     o_launch,
  output logic                     o_busy,
  output logic                     o_finish,
  output logic [2:0]               o_err,
  output logic [CNT_W-1:0]         o_run_cnt
);

  // Timeout counter only needs to reach TIMEOUT-1, where it saturates.
  localparam int                TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TLIM   = TCNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit                TO_EN  = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [CFG_W-1:0]         r_shadow [N_REGS];
  logic [CFG_W-1:0]         r_active [N_REGS];
  logic [CFG_W-1:0]         w_rd_word;
  logic [CFG_W-1:0]         r_rd_data;
  logic                     r_rd_valid;
  logic [TCNT_W-1:0]        r_tcnt;
  logic [CNT_W-1:0]         r_run_cnt;
  logic [2:0]               r_err;
  logic [2:0]               w_err_set;
  logic                     w_addr_ok;
  logic                     w_wr_ok;
  logic                     w_commit;
  logic                     w_tmo;
  logic                     w_launch_nxt;
  logic                     w_busy_nxt;
  logic                     w_finish_nxt;
  logic                     r_launch;
  logic                     r_busy;
  logic                     r_finish;
  logic [N_REGS*CFG_W-1:0]  w_active_flat;

  assign w_addr_ok = (32'(i_cfg_addr) < 32'(N_REGS));
  assign w_wr_ok   = i_cfg_wr_en & w_addr_ok;
  assign w_commit  = (r_state == S_IDLE) & i_start;
  assign w_tmo     = TO_EN & (r_state == S_RUN) & ~i_core_done & (r_tcnt == TLIM);

  // Error sources: [0] out-of-range access, [1] start while busy, [2] run timeout.
  assign w_err_set = {w_tmo,
                      i_start & (r_state != S_IDLE),
                      (i_cfg_wr_en | i_cfg_rd_en) & ~w_addr_ok};

  // Shadow bank: host writes land here in any state; out-of-range writes drop.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < N_REGS; k++) r_shadow[k] <= '0;
    end else begin
      for (int k = 0; k < N_REGS; k++) begin
        if (w_wr_ok && (i_cfg_addr == ADDR_W'(k))) r_shadow[k] <= i_cfg;
      end
    end
  end

  // Active bank: atomic copy of shadow on start, bypassing a same-cycle write.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < N_REGS; k++) r_active[k] <= '0;
    end else if (w_commit) begin
      for (int k = 0; k < N_REGS; k++) begin
        r_active[k] <= (w_wr_ok && (i_cfg_addr == ADDR_W'(k))) ? i_cfg : r_shadow[k];
      end
    end
  end

  // Read mux: unmatched (out-of-range) addresses read as zero.
  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < N_REGS; k++) begin
      w_rd_word = (i_cfg_addr == ADDR_W'(k))
                ? (i_cfg_rd_active ? r_active[k] : r_shadow[k])
                : w_rd_word;
    end
  end

  // Registered readback: pre-write shadow contents are returned on a collision.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= i_cfg_rd_en;
      if (i_cfg_rd_en) r_rd_data <= w_rd_word;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next-state logic; completion or timeout ends a run.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = i_start ? S_LAUNCH : S_IDLE;
      S_LAUNCH: w_next = S_RUN;
      S_RUN: begin
        if (i_core_done || w_tmo) w_next = S_DONE;
        else                      w_next = S_RUN;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM output decode on the next state, so the output flops line up with it.
  always_comb begin
    w_launch_nxt = 1'b0;
    w_busy_nxt   = 1'b0;
    w_finish_nxt = 1'b0;
    case (w_next)
      S_IDLE:   w_busy_nxt = 1'b0;
      S_LAUNCH: begin w_launch_nxt = 1'b1; w_busy_nxt = 1'b1; end
      S_RUN:    w_busy_nxt = 1'b1;
      S_DONE:   begin w_finish_nxt = 1'b1; w_busy_nxt = 1'b1; end
      default:  w_busy_nxt = 1'b0;
    endcase
  end

  // Output flops for the control strobes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_launch <= 1'b0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_launch <= w_launch_nxt;
      r_busy   <= w_busy_nxt;
      r_finish <= w_finish_nxt;
    end
  end

  // Timeout counter: zero in IDLE, so it reads 0 in LAUNCH; saturates at the limit.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                  r_tcnt <= '0;
    else if (r_state == S_IDLE)  r_tcnt <= '0;
    else if (r_tcnt != TLIM)     r_tcnt <= r_tcnt + TCNT_W'(1);
  end

  // Completed-run counter, bumped as DONE retires; wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                  r_run_cnt <= '0;
    else if (r_state == S_DONE)  r_run_cnt <= r_run_cnt + CNT_W'(1);
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)         r_err <= 3'b000;
    else if (i_err_clr) r_err <= w_err_set;
    else                r_err <= r_err | w_err_set;
  end

  // Flatten the active bank onto the datapath bus.
  always_comb begin
    w_active_flat = '0;
    for (int k = 0; k < N_REGS; k++) w_active_flat[k*CFG_W +: CFG_W] = r_active[k];
  end

  assign o_cfg_active   = w_active_flat;
  assign o_cfg_rd_data  = r_rd_data;
  assign o_cfg_rd_valid = r_rd_valid;
  assign o_launch       = r_launch;
  assign o_busy         = r_busy;
  assign o_finish       = r_finish;
  assign o_err          = r_err;
  assign o_run_cnt      = r_run_cnt;

endmodule

// File: tb/tb_cfg_regfile_ctrl.sv
// Directed bench for cfg_regfile_ctrl. Instance a: 4 regs, no timeout, 8-bit
// run counter. Instance b: 3 regs, TIMEOUT=8, 2-bit run counter. Both share
// the same stimulus; each section checks the instance it targets.
module tb_cfg_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg = 16'h0000;
  logic [1:0]  addr = 2'd0;
  logic        wr_en = 1'b0, rd_en = 1'b0, rd_act = 1'b0;
  logic        start = 1'b0, done = 1'b0, err_clr = 1'b0;

  logic [15:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid;
  logic [63:0] a_active;
  logic [47:0] b_active;
  logic        a_launch, a_busy, a_finish, b_launch, b_busy, b_finish;
  logic [2:0]  a_err, b_err;
  logic [7:0]  a_run_cnt;
  logic [1:0]  b_run_cnt;

  int total = 0;
  int bad   = 0;
  int n;
  logic [15:0] shv [4];

  cfg_regfile_ctrl #(.CFG_W(16), .N_REGS(4), .ADDR_W(2), .TIMEOUT(0), .CNT_W(8)) u_a (
    .i_clk(clk), .i_rst(rst_n), .i_cfg(cfg), .i_cfg_addr(addr),
    .i_cfg_wr_en(wr_en), .i_cfg_rd_en(rd_en), .i_cfg_rd_active(rd_act),
    .o_cfg_rd_data(a_rd_data), .o_cfg_rd_valid(a_rd_valid),
    .i_start(start), .i_core_done(done), .i_err_clr(err_clr),
    .o_cfg_active(a_active), .o_launch(a_launch), .o_busy(a_busy),
    .o_finish(a_finish), .o_err(a_err), .o_run_cnt(a_run_cnt)
  );

  cfg_regfile_ctrl #(.CFG_W(16), .N_REGS(3), .ADDR_W(2), .TIMEOUT(8), .CNT_W(2)) u_b (
    .i_clk(clk), .i_rst(rst_n), .i_cfg(cfg), .i_cfg_addr(addr),
    .i_cfg_wr_en(wr_en), .i_cfg_rd_en(rd_en), .i_cfg_rd_active(rd_act),
    .o_cfg_rd_data(b_rd_data), .o_cfg_rd_valid(b_rd_valid),
    .i_start(start), .i_core_done(done), .i_err_clr(err_clr),
    .o_cfg_active(b_active), .o_launch(b_launch), .o_busy(b_busy),
    .o_finish(b_finish), .o_err(b_err), .o_run_cnt(b_run_cnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    shv[0] = 16'hCE00; shv[1] = 16'h0404; shv[2] = 16'h0003; shv[3] = 16'd200;

    // Reset state
    repeat (2) tick();
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_launch", 64'(a_launch), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_active", a_active, 64'd0);
    chk("rst_cnt", 64'(a_run_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Fill shadow bank, then read it back and check active is still zero
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; addr = 2'(k); cfg = shv[k];
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1; addr = 2'(k); rd_act = 1'b0;
      tick();
      chk("rd_sh_valid", 64'(a_rd_valid), 64'd1);
      chk("rd_sh_data", 64'(a_rd_data), 64'(shv[k]));
    end
    rd_en = 1'b0;
    tick();
    chk("rd_valid_drop", 64'(a_rd_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1; addr = 2'(k); rd_act = 1'b1;
      tick();
      chk("rd_act_zero", 64'(a_rd_data), 64'd0);
    end
    rd_en = 1'b0; rd_act = 1'b0;

    // Run 1: launch latency, commit, 10 RUN cycles, finish
    start = 1'b1;
    tick();
    chk("r1_launch", 64'(a_launch), 64'd1);
    chk("r1_busy", 64'(a_busy), 64'd1);
    chk("r1_commit", a_active, 64'h00C8_0003_0404_CE00);
    start = 1'b0;
    tick();
    chk("r1_launch_1cyc", 64'(a_launch), 64'd0);
    repeat (9) tick();
    chk("r1_no_finish", 64'(a_finish), 64'd0);
    done = 1'b1;
    tick();
    chk("r1_finish", 64'(a_finish), 64'd1);
    done = 1'b0;
    tick();
    chk("r1_finish_1cyc", 64'(a_finish), 64'd0);
    chk("r1_idle", 64'(a_busy), 64'd0);
    chk("r1_cnt", 64'(a_run_cnt), 64'd1);
    chk("r1_err", 64'(a_err), 64'd0);

    // Run 2: write + start while busy
    start = 1'b1; tick();
    start = 1'b0; tick();
    wr_en = 1'b1; addr = 2'd1; cfg = 16'hFFFF; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("busy_err", 64'(a_err), 64'b010);
    chk("busy_act1", 64'(a_active[31:16]), 64'h0404);
    rd_en = 1'b1; addr = 2'd1; rd_act = 1'b0;
    tick();
    chk("busy_rd_sh1", 64'(a_rd_data), 64'hFFFF);
    rd_act = 1'b1;
    tick();
    chk("busy_rd_act1", 64'(a_rd_data), 64'h0404);
    rd_en = 1'b0; rd_act = 1'b0;
    done = 1'b1; tick();
    done = 1'b0;
    chk("r2_finish", 64'(a_finish), 64'd1);
    tick();
    chk("r2_cnt", 64'(a_run_cnt), 64'd2);
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    chk("err_clr", 64'(a_err), 64'd0);

    // Run 3: commits the protected write; done during LAUNCH is ignored
    start = 1'b1; tick();
    start = 1'b0;
    chk("r3_commit", a_active, 64'h00C8_0003_FFFF_CE00);
    done = 1'b1;
    tick();
    chk("r3_done_in_launch", 64'(a_finish), 64'd0);
    tick();
    chk("r3_finish", 64'(a_finish), 64'd1);
    done = 1'b0;
    tick();
    chk("r3_cnt", 64'(a_run_cnt), 64'd3);

    // Async reset in the middle of RUN
    start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(a_busy), 64'd0);
    chk("arst_active", a_active, 64'd0);
    chk("arst_cnt", 64'(a_run_cnt), 64'd0);
    done = 1'b1;
    tick();
    chk("arst_no_finish", 64'(a_finish), 64'd0);
    done = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Instance b: timeout forces finish 8 cycles after LAUNCH
    start = 1'b1; tick();
    start = 1'b0;
    chk("tmo_launch", 64'(b_launch), 64'd1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (b_finish) begin
        n = i;
        break;
      end
    end
    chk("tmo_latency", 64'(n), 64'd8);
    chk("tmo_err", 64'(b_err), 64'b100);
    tick();
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    chk("tmo_err_clr", 64'(b_err), 64'd0);

    // Instance b: out-of-range access and write/start bypass
    wr_en = 1'b1; addr = 2'd0; cfg = 16'h1111; tick();
    addr = 2'd3; cfg = 16'h1234; tick();
    wr_en = 1'b0;
    chk("badaddr_err", 64'(b_err), 64'b001);
    rd_en = 1'b1; addr = 2'd3; tick();
    rd_en = 1'b0;
    chk("badaddr_rd", 64'(b_rd_data), 64'd0);
    wr_en = 1'b1; addr = 2'd2; cfg = 16'hBEEF; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("bypass_launch", 64'(b_launch), 64'd1);
    chk("bypass_commit", 64'(b_active), 64'h0000_BEEF_0000_1111);
    done = 1'b1; tick(); tick();
    done = 1'b0; tick();
    chk("b_idle", 64'(b_busy), 64'd0);

    // Back-to-back runs with start and done held high
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    start = 1'b1; done = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("b2b_launch_a", 64'(a_launch), 64'((i % 4) == 1));
      chk("b2b_launch_b", 64'(b_launch), 64'((i % 4) == 1));
      if (i == 12) begin
        chk("b2b_cnt3_a", 64'(a_run_cnt), 64'd3);
        chk("b2b_cnt3_b", 64'(b_run_cnt), 64'd3);
      end
    end
    chk("b2b_cnt4_a", 64'(a_run_cnt), 64'd4);
    chk("b2b_wrap_b", 64'(b_run_cnt), 64'd0);
    start = 1'b0; done = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
